// File: rtl/wb_cmd_pkg.sv
// Shared command/response byte values and FSM state encoding for wb_cmd_master.
package wb_cmd_pkg;

    // Host command bytes (first byte of every frame).
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    // Response lead bytes sent back to the host.
    localparam logic [7:0] RSP_WRITE_OK = 8'h81;
    localparam logic [7:0] RSP_READ_OK  = 8'h82;
    localparam logic [7:0] RSP_BAD_CMD  = 8'hEE;
    localparam logic [7:0] RSP_TIMEOUT  = 8'hEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator driven by a byte-stream command protocol.
// Each host frame (write: 01 addr[4] data[4], read: 02 addr[4]) produces
// exactly one single-word bus cycle and one response frame on the tx side.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int timeout_cycles = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy
);

    localparam int              TMO_W    = $clog2(timeout_cycles + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_cycles - 1);

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      dat_q, dat_d;
    logic             cyc_q, cyc_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [39:0]      resp_q, resp_d;
    logic [2:0]       resp_cnt_q, resp_cnt_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q;

    // Next-state, frame decode, bus handshake and response serializer.
    always_comb begin
        // NOTE: every _d takes its _q value first, so a branch that does not
        // assign it holds the register instead of inferring a latch.
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        cyc_d      = cyc_q;
        tmo_d      = tmo_q;
        resp_d     = resp_q;
        resp_cnt_d = resp_cnt_q;
        tx_valid_d = tx_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_stb) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        we_d       = (rx_data == CMD_WRITE);
                        byte_cnt_d = 2'd0;
                        state_d    = ST_ADDR;
                    end else begin
                        resp_d     = {RSP_BAD_CMD, 32'h0};
                        resp_cnt_d = 3'd1;
                        tx_valid_d = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end

            ST_ADDR: begin
                if (rx_stb) begin
                    adr_d      = {adr_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (we_q) begin
                            state_d = ST_DATA;
                        end else begin
                            cyc_d   = 1'b1;
                            tmo_d   = '0;
                            state_d = ST_BUS;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (rx_stb) begin
                    dat_d      = {dat_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        cyc_d   = 1'b1;
                        tmo_d   = '0;
                        state_d = ST_BUS;
                    end
                end
            end

            ST_BUS: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (wb_ack_i) begin
                    cyc_d      = 1'b0;
                    resp_d     = we_q ? {RSP_WRITE_OK, 32'h0} : {RSP_READ_OK, wb_dat_i};
                    resp_cnt_d = we_q ? 3'd1 : 3'd5;
                    tx_valid_d = 1'b1;
                    state_d    = ST_RESP;
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d      = 1'b0;
                    resp_d     = {RSP_TIMEOUT, 32'h0};
                    resp_cnt_d = 3'd1;
                    tx_valid_d = 1'b1;
                    state_d    = ST_RESP;
                end
            end

            ST_RESP: begin
                // tx_valid is always high here, so tx_ready alone completes the handshake.
                if (tx_ready) begin
                    resp_d     = {resp_q[31:0], 8'h00};
                    resp_cnt_d = resp_cnt_q - 3'd1;
                    if (resp_cnt_q == 3'd1) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, dropping any bus cycle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            cyc_q      <= 1'b0;
            tmo_q      <= '0;
            // NOTE: the response shift register is reset like any flop because
            // tx_data is taken directly from its top byte.
            resp_q     <= '0;
            resp_cnt_q <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            cyc_q      <= cyc_d;
            tmo_q      <= tmo_d;
            resp_q     <= resp_d;
            resp_cnt_q <= resp_cnt_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = 4'hF;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign tx_data  = resp_q[39:32];
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed scenarios plus a randomized
// frame stream checked against a frame-level reference model.
module tb_wb_cmd_master;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_stb = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
    logic        busy;

    int checks = 0;
    int failures = 0;

    wb_cmd_master #(.timeout_cycles(TMO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_stb(rx_stb),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural slave ----------------
    int          ack_delay = 0;
    bit          slave_en = 1'b1;
    bit          ack_force = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] slv_mem [logic [31:0]];

    assign wb_ack_i = ack_force || (slave_en && wb_cyc_o && wb_stb_o && (wait_cnt >= ack_delay));

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (wb_cyc_o && wb_stb_o && wb_ack_i && wb_we_o) slv_mem[wb_adr_o] = wb_dat_o;
    end

    always @(negedge clk) begin
        if (wb_cyc_o && !wb_we_o)
            wb_dat_i <= slv_mem.exists(wb_adr_o) ? slv_mem[wb_adr_o] : (32'hDEAD_0000 ^ wb_adr_o);
        else
            wb_dat_i <= 32'h0;
    end

    // ---------------- monitors ----------------
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } txn_t;

    txn_t       bus_q[$];
    logic [7:0] tx_q[$];
    int         cyc_run = 0;
    int         last_cyc_len = 0;

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && wb_ack_i) bus_q.push_back({wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o});
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (wb_cyc_o) begin
            cyc_run      <= cyc_run + 1;
            last_cyc_len <= cyc_run + 1;
        end else begin
            cyc_run <= 0;
        end
    end

    bit rand_ready = 1'b0;
    always @(negedge clk) if (rand_ready) tx_ready = ($urandom_range(0, 2) != 0);

    // ---------------- helpers (all entered and left on a negedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_stb  = 1'b1;
        @(negedge clk);
        rx_stb  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$]);
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic wait_bus_end();
        int n = 0;
        while (wb_cyc_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wb_cyc_o) begin
            failures++;
            $display("FAIL bus_end_wait: cyc still high after %0d clocks, required low", n);
        end
    endtask

    task automatic collect(input int n, output int used);
        used = 0;
        while (tx_q.size() < n && used < 400) begin
            @(negedge clk);
            used++;
        end
        checks++;
        if (tx_q.size() != n) begin
            failures++;
            $display("FAIL rsp_count: got %0d bytes, required %0d", tx_q.size(), n);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[31 - 8*i -: 8];
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #11;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, tx_valid, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: cyc/stb/we/txv/busy=%b required 00000",
                     {wb_cyc_o, wb_stb_o, wb_we_o, tx_valid, busy});
        end
        checks++;
        if (wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_adr_dat: adr=%h dat=%h required 0", wb_adr_o, wb_dat_o);
        end
        checks++;
        if (tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx_data: got %h required 00", tx_data);
        end
        checks++;
        if (wb_sel_o !== 4'hF) begin
            failures++;
            $display("FAIL reset_sel: got %h required F", wb_sel_o);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b txv=%b required 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_write();
        int used;
        txn_t t;
        slave_en = 1; ack_delay = 2; tx_ready = 1;
        bus_q.delete(); tx_q.delete();
        send_frame('{8'h01, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5});
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
            failures++;
            $display("FAIL wr_cyc_rise: cyc=%b stb=%b required 1 1", wb_cyc_o, wb_stb_o);
        end
        wait_bus_end();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h81) begin
            failures++;
            $display("FAIL wr_txv_rise: txv=%b data=%h required 1 81", tx_valid, tx_data);
        end
        checks++;
        if (last_cyc_len != 3) begin
            failures++;
            $display("FAIL wr_cyc_len: got %0d required 3", last_cyc_len);
        end
        checks++;
        if (bus_q.size() != 1) begin
            failures++;
            $display("FAIL wr_txn_count: got %0d required 1", bus_q.size());
        end else begin
            t = bus_q.pop_front();
            checks++;
            if (t !== {32'h4000_0000, 32'h0000_00A5, 1'b1, 4'hF}) begin
                failures++;
                $display("FAIL wr_txn: adr=%h dat=%h we=%b sel=%h required 40000000 000000a5 1 f",
                         t.adr, t.dat, t.we, t.sel);
            end
        end
        collect(1, used);
        checks++;
        if (tx_q.size() == 1 && tx_q[0] !== 8'h81) begin
            failures++;
            $display("FAIL wr_rsp: got %h required 81", tx_q[0]);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wr_busy_fall: got %b required 0", busy);
        end
    endtask

    task automatic test_read();
        int used;
        txn_t t;
        logic [7:0] exp[5] = '{8'h82, 8'h12, 8'h34, 8'h56, 8'h78};
        slv_mem[32'h2000_0004] = 32'h1234_5678;
        slave_en = 1; ack_delay = 0; tx_ready = 1;
        bus_q.delete(); tx_q.delete();
        send_frame('{8'h02, 8'h20, 8'h00, 8'h00, 8'h04});
        wait_bus_end();
        checks++;
        if (last_cyc_len != 1) begin
            failures++;
            $display("FAIL rd_cyc_len: got %0d required 1", last_cyc_len);
        end
        checks++;
        if (bus_q.size() != 1) begin
            failures++;
            $display("FAIL rd_txn_count: got %0d required 1", bus_q.size());
        end else begin
            t = bus_q.pop_front();
            checks++;
            if (t.adr !== 32'h2000_0004 || t.we !== 1'b0 || t.sel !== 4'hF) begin
                failures++;
                $display("FAIL rd_txn: adr=%h we=%b sel=%h required 20000004 0 f", t.adr, t.we, t.sel);
            end
        end
        collect(5, used);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i < tx_q.size() && tx_q[i] !== exp[i]) begin
                failures++;
                $display("FAIL rd_rsp_byte%0d: got %h required %h", i, tx_q[i], exp[i]);
            end
        end
        checks++;
        if (used != 5) begin
            failures++;
            $display("FAIL rd_throughput: %0d clocks for 5 bytes, required 5", used);
        end
    endtask

    task automatic test_timeout();
        int used;
        bit quiet = 1'b1;
        slave_en = 0; tx_ready = 1;
        bus_q.delete(); tx_q.delete();
        send_frame('{8'h02, 8'h70, 8'h00, 8'h00, 8'h00});
        wait_bus_end();
        checks++;
        if (last_cyc_len != TMO) begin
            failures++;
            $display("FAIL tmo_cyc_len: got %0d required %0d", last_cyc_len, TMO);
        end
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEF) begin
            failures++;
            $display("FAIL tmo_rsp: txv=%b data=%h required 1 ef", tx_valid, tx_data);
        end
        collect(1, used);
        @(negedge clk);
        ack_force = 1;
        @(negedge clk);
        ack_force = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_cyc_o !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet || bus_q.size() != 0 || tx_q.size() != 1) begin
            failures++;
            $display("FAIL late_ack: quiet=%b txns=%0d tx_bytes=%0d required 1 0 1",
                     quiet, bus_q.size(), tx_q.size());
        end
        slave_en = 1;
    endtask

    task automatic test_bad_cmd();
        int used;
        tx_ready = 1; tx_q.delete();
        send_byte(8'h55);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
            failures++;
            $display("FAIL bad_cmd_rsp: txv=%b data=%h required 1 ee", tx_valid, tx_data);
        end
        collect(1, used);
        checks++;
        if (busy !== 1'b0 || wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL bad_cmd_idle: busy=%b cyc=%b required 0 0", busy, wb_cyc_o);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[5] = '{8'h82, 8'hCA, 8'hFE, 8'h00, 8'h11};
        slv_mem[32'h0000_0100] = 32'hCAFE_0011;
        slave_en = 1; ack_delay = 1; tx_ready = 0;
        tx_q.delete();
        send_frame('{8'h02, 8'h00, 8'h00, 8'h01, 8'h00});
        wait_bus_end();
        for (int i = 0; i < 5; i++) begin
            bit stable = 1'b1;
            logic [7:0] seen = tx_data;
            for (int k = 0; k < 10; k++) begin
                if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                    stable = 1'b0;
                    seen = tx_data;
                end
                @(negedge clk);
            end
            checks++;
            if (!stable) begin
                failures++;
                $display("FAIL bp_hold_byte%0d: saw %h (or txv low), required %h held", i, seen, exp[i]);
            end
            tx_ready = 1;
            @(negedge clk);
            tx_ready = 0;
        end
        checks++;
        if (tx_q.size() != 5 || tx_q[0] !== 8'h82 || tx_q[1] !== 8'hCA || tx_q[2] !== 8'hFE ||
            tx_q[3] !== 8'h00 || tx_q[4] !== 8'h11) begin
            failures++;
            $display("FAIL bp_order: got %0d bytes, required 82 ca fe 00 11", tx_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_busy: got %b required 0", busy);
        end
        tx_ready = 1;
    endtask

    task automatic test_back_to_back();
        int used;
        slave_en = 1; ack_delay = 1; tx_ready = 1;
        tx_q.delete();
        send_frame('{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h89, 8'hAB, 8'hCD, 8'hEF});
        wait_bus_end();
        collect(1, used);
        tx_q.delete();
        send_frame('{8'h02, 8'h00, 8'h00, 8'h02, 8'h00});
        wait_bus_end();
        collect(5, used);
        checks++;
        if (tx_q.size() != 5 || tx_q[0] !== 8'h82 || tx_q[1] !== 8'h89 || tx_q[2] !== 8'hAB ||
            tx_q[3] !== 8'hCD || tx_q[4] !== 8'hEF) begin
            failures++;
            $display("FAIL b2b_read: got %0d bytes first %h, required 82 89 ab cd ef",
                     tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'h00);
        end
        tx_q.delete();
        send_byte(8'h33);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
            failures++;
            $display("FAIL b2b_cmd_accept: txv=%b data=%h required 1 ee", tx_valid, tx_data);
        end
        collect(1, used);
    endtask

    task automatic test_drops();
        int used;
        slave_en = 1; ack_delay = 8; tx_ready = 0;
        bus_q.delete(); tx_q.delete();
        send_frame('{8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h5A, 8'h5A, 8'h00, 8'h01});
        send_frame('{8'h02, 8'h01, 8'h55});
        wait_bus_end();
        checks++;
        if (last_cyc_len != 9) begin
            failures++;
            $display("FAIL drop_bus_len: got %0d required 9", last_cyc_len);
        end
        send_frame('{8'h01, 8'h02});
        tx_ready = 1;
        collect(1, used);
        checks++;
        if (tx_q[0] !== 8'h81 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_rsp: got %h busy=%b required 81 0", tx_q[0], busy);
        end
        tx_q.delete();
        ack_delay = 0;
        send_frame('{8'h02, 8'h00, 8'h00, 8'h03, 8'h00});
        wait_bus_end();
        collect(5, used);
        checks++;
        if (tx_q.size() != 5 || tx_q[1] !== 8'h5A || tx_q[2] !== 8'h5A || tx_q[3] !== 8'h00 ||
            tx_q[4] !== 8'h01 || bus_q.size() != 2) begin
            failures++;
            $display("FAIL drop_next_frame: bytes=%0d txns=%0d required 5 bytes 82 5a 5a 00 01, 2 txns",
                     tx_q.size(), bus_q.size());
        end
    endtask

    task automatic test_reset_mid_bus();
        int used;
        txn_t t;
        slave_en = 0; tx_ready = 1;
        bus_q.delete(); tx_q.delete();
        send_frame('{8'h02, 8'h30, 8'h00, 8'h00, 8'h00});
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, tx_valid, busy} !== 4'b0) begin
            failures++;
            $display("FAIL reset_mid_bus: cyc/stb/txv/busy=%b required 0000",
                     {wb_cyc_o, wb_stb_o, tx_valid, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        slave_en = 1; ack_delay = 1;
        repeat (20) @(negedge clk);
        checks++;
        if (tx_q.size() != 0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_rsp: bytes=%0d txv=%b required 0 0", tx_q.size(), tx_valid);
        end
        send_frame('{8'h01, 8'h50, 8'h00, 8'h00, 8'h08, 8'h01, 8'h23, 8'h45, 8'h67});
        wait_bus_end();
        collect(1, used);
        checks++;
        if (bus_q.size() != 1 || tx_q[0] !== 8'h81) begin
            failures++;
            $display("FAIL post_reset_write: txns=%0d rsp=%h required 1 81", bus_q.size(), tx_q[0]);
        end else begin
            t = bus_q.pop_front();
            checks++;
            if (t !== {32'h5000_0008, 32'h0123_4567, 1'b1, 4'hF}) begin
                failures++;
                $display("FAIL post_reset_txn: adr=%h dat=%h we=%b required 50000008 01234567 1",
                         t.adr, t.dat, t.we);
            end
        end
    endtask

    // Random frame stream against a frame-level model: a sparse word memory
    // plus the response byte rules for write / read / timeout / unknown command.
    task automatic test_random();
        logic [31:0] ref_mem [logic [31:0]];
        slv_mem.delete();
        rand_ready = 1;
        for (int it = 0; it < 40; it++) begin
            int          kind = $urandom_range(0, 5);
            logic [31:0] a = 32'h1000_0000 * $urandom_range(5, 7) + 4 * $urandom_range(0, 3);
            logic [31:0] d = $urandom;
            logic [7:0]  fr[$];
            logic [7:0]  exp[$];
            txn_t        exp_t;
            int          exp_len;
            int          used;
            bit          ok;
            bus_q.delete(); tx_q.delete();
            ack_delay = $urandom_range(0, 5);
            slave_en  = (kind != 5);
            exp_len   = (kind == 5) ? TMO : ack_delay + 1;
            if (kind == 4) begin
                logic [7:0] b;
                do b = 8'($urandom_range(0, 255)); while (b == 8'h01 || b == 8'h02);
                fr.push_back(b);
                exp.push_back(8'hEE);
            end else begin
                fr.push_back(kind <= 1 ? 8'h01 : 8'h02);
                for (int i = 0; i < 4; i++) fr.push_back(byte_of(a, i));
                if (kind <= 1) begin
                    for (int i = 0; i < 4; i++) fr.push_back(byte_of(d, i));
                    ref_mem[a] = d;
                    exp.push_back(8'h81);
                    exp_t = {a, d, 1'b1, 4'hF};
                end else if (kind <= 3) begin
                    logic [31:0] rd = ref_mem.exists(a) ? ref_mem[a] : (32'hDEAD_0000 ^ a);
                    exp.push_back(8'h82);
                    for (int i = 0; i < 4; i++) exp.push_back(byte_of(rd, i));
                end else begin
                    exp.push_back(8'hEF);
                end
            end
            send_frame(fr);
            if (kind != 4) begin
                wait_bus_end();
                checks++;
                if (last_cyc_len != exp_len) begin
                    failures++;
                    $display("FAIL rand%0d_cyc_len: got %0d required %0d", it, last_cyc_len, exp_len);
                end
                if (kind <= 3) begin
                    checks++;
                    if (bus_q.size() != 1 || bus_q[0].adr !== a || bus_q[0].we !== (kind <= 1) ||
                        (kind <= 1 && bus_q[0] !== exp_t)) begin
                        failures++;
                        $display("FAIL rand%0d_txn: txns=%0d adr=%h required 1 %h",
                                 it, bus_q.size(), bus_q.size() > 0 ? bus_q[0].adr : 32'h0, a);
                    end
                end
            end
            collect(exp.size(), used);
            ok = (tx_q.size() == exp.size());
            for (int i = 0; i < exp.size() && i < tx_q.size(); i++) if (tx_q[i] !== exp[i]) ok = 0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rand%0d_rsp: got %0d bytes first %h, required %0d bytes first %h",
                         it, tx_q.size(), tx_q.size() > 0 ? tx_q[0] : 8'h00, exp.size(), exp[0]);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d_busy: got %b required 0", it, busy);
            end
        end
        rand_ready = 0;
        tx_ready = 1;
        slave_en = 1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_bad_cmd();
        test_backpressure();
        test_back_to_back();
        test_drops();
        test_reset_mid_bus();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
